// File: rtl/pcie_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : pcie_axil_master
// Description : Single-outstanding request/response to AXI4-Lite initiator
//               with a per-transaction abort timer and sticky abort flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_axil_master #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      timed_out,
    output logic [ADDR_WIDTH-1:0]     m_axi_pcie_awaddr,
    output logic                      m_axi_pcie_awvalid,
    input  logic                      m_axi_pcie_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_pcie_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_pcie_wstrb,
    output logic                      m_axi_pcie_wvalid,
    input  logic                      m_axi_pcie_wready,
    input  logic [1:0]                m_axi_pcie_bresp,
    input  logic                      m_axi_pcie_bvalid,
    output logic                      m_axi_pcie_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_pcie_araddr,
    output logic                      m_axi_pcie_arvalid,
    input  logic                      m_axi_pcie_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_pcie_rdata,
    input  logic [1:0]                m_axi_pcie_rresp,
    input  logic                      m_axi_pcie_rvalid,
    output logic                      m_axi_pcie_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ~ADDR_WIDTH'(7);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR   = 3'd3,
        S_WR_B = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timed_out_q, timed_out_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic w_accept;
    logic w_expire;
    logic w_abort;

    // Requests are only taken while idle and never after an abort, so a late
    // beat from a recovering partition cannot land in a new transaction.
    assign req_ready = (state_q == S_IDLE) && !timed_out_q;
    assign w_accept  = req_valid && req_ready;

    // Next-state, channel handshakes, abort timer and response capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timed_out_d   = timed_out_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        w_abort       = 1'b0;
        w_expire      = (cnt_q == C_CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cnt_d = '0;
                    if (req_write) begin
                        awaddr_d  = req_addr & C_ALIGN_MASK;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        araddr_d  = req_addr & C_ALIGN_MASK;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                cnt_d = cnt_q + 1'b1;
                if (w_expire) begin
                    w_abort = 1'b1;
                end else if (m_axi_pcie_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                cnt_d = cnt_q + 1'b1;
                // A data beat arriving on the expiry cycle still completes.
                if (m_axi_pcie_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi_pcie_rdata;
                    rsp_resp_d    = m_axi_pcie_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else if (w_expire) begin
                    w_abort = 1'b1;
                end
            end
            S_WR: begin
                cnt_d = cnt_q + 1'b1;
                if (w_expire) begin
                    w_abort = 1'b1;
                end else begin
                    awvalid_d = awvalid_q && !m_axi_pcie_awready;
                    wvalid_d  = wvalid_q && !m_axi_pcie_wready;
                    if (!awvalid_d && !wvalid_d) begin
                        bready_d = 1'b1;
                        state_d  = S_WR_B;
                    end
                end
            end
            S_WR_B: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axi_pcie_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi_pcie_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else if (w_expire) begin
                    w_abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b00;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: drop every channel and return SLVERR flagged as a timeout.
        if (w_abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            timed_out_d   = 1'b1;
            state_d       = S_RSP;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            timed_out_q   <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timed_out_q   <= timed_out_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_resp           = rsp_resp_q;
    assign rsp_timeout        = rsp_timeout_q;
    assign timed_out          = timed_out_q;
    assign m_axi_pcie_awaddr  = awaddr_q;
    assign m_axi_pcie_awvalid = awvalid_q;
    assign m_axi_pcie_wdata   = wdata_q;
    assign m_axi_pcie_wstrb   = wstrb_q;
    assign m_axi_pcie_wvalid  = wvalid_q;
    assign m_axi_pcie_bready  = bready_q;
    assign m_axi_pcie_araddr  = araddr_q;
    assign m_axi_pcie_arvalid = arvalid_q;
    assign m_axi_pcie_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_axil_master
// Description : Self-checking bench for pcie_axil_master: table vectors,
//               randomized transactions against a latency/response model,
//               reset-in-flight and timeout sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_axil_master;

    localparam int AW = 22;
    localparam int DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [7:0]    req_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout, timed_out;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [7:0]    wstrb;
    logic [1:0]    bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;

    pcie_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .timed_out(timed_out),
        .m_axi_pcie_awaddr(awaddr), .m_axi_pcie_awvalid(awvalid), .m_axi_pcie_awready(awready),
        .m_axi_pcie_wdata(wdata), .m_axi_pcie_wstrb(wstrb), .m_axi_pcie_wvalid(wvalid),
        .m_axi_pcie_wready(wready), .m_axi_pcie_bresp(bresp), .m_axi_pcie_bvalid(bvalid),
        .m_axi_pcie_bready(bready), .m_axi_pcie_araddr(araddr), .m_axi_pcie_arvalid(arvalid),
        .m_axi_pcie_arready(arready), .m_axi_pcie_rdata(rdata), .m_axi_pcie_rresp(rresp),
        .m_axi_pcie_rvalid(rvalid), .m_axi_pcie_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [7:0]    ws;
        int            ar_w, r_w, aw_w, w_w, b_w;
        logic [DW-1:0] sdata;
        logic [1:0]    sresp;
        int            hold;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
    } txn_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference timing: one cycle to issue, waits on each channel, one cycle
    // for the data/response beat, one to present the response.
    function automatic int model_lat(input txn_t t);
        int m;
        if (t.wr) begin
            m = (t.aw_w > t.w_w) ? t.aw_w : t.w_w;
            return 3 + m + t.b_w;
        end
        return 3 + t.ar_w + t.r_w;
    endfunction

    task automatic slave_idle();
        arready = 0; rvalid = 0; rdata = '0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    // Drive one request, act as the AXI slave with the given wait states,
    // and check handshakes, latency and the returned response.
    task automatic run_txn(input txn_t t, input string nm);
        int c, ar_seen, aw_seen, w_seen, ar_hi, rr_hi, aw_hi, w_hi, b_hi;
        int r_start, b_start, aw_hs, w_hs, rsp_c, rsp_n;
        bit ar_done, r_done, b_done, consumed, overlap, rdy_bad, unstable, got, addr_seen;
        logic [DW-1:0] cap_rdata, cap_wdata;
        logic [1:0]    cap_resp;
        logic          cap_to;
        logic [AW-1:0] cap_addr;
        logic [7:0]    cap_wstrb;
        logic [AW-1:0] exp_addr;
        ar_seen = 0; aw_seen = 0; w_seen = 0; ar_hi = 0; rr_hi = 0; aw_hi = 0; w_hi = 0; b_hi = 0;
        r_start = 0; b_start = 0; aw_hs = -1; w_hs = -1; rsp_c = -1; rsp_n = 0;
        ar_done = 0; r_done = 0; b_done = 0; consumed = 0; overlap = 0; rdy_bad = 0;
        unstable = 0; got = 0; addr_seen = 0;
        cap_rdata = '0; cap_wdata = '0; cap_resp = 0; cap_to = 0; cap_addr = '0; cap_wstrb = '0;
        exp_addr = t.addr;
        exp_addr[2:0] = 3'b000;

        @(negedge clk);
        req_valid = 1; req_write = t.wr; req_addr = t.addr; req_wdata = t.wd; req_wstrb = t.ws;
        c = 0;
        while (!req_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!req_ready) begin
            chk({nm, " accept"}, 64'(req_ready), 64'(1));
            req_valid = 0;
            return;
        end
        @(negedge clk);
        req_valid = 0;
        c = 1;
        while (!consumed && c < 100) begin
            if (arvalid && awvalid) overlap = 1;
            if (req_ready) rdy_bad = 1;
            if (arvalid) begin
                ar_hi++;
                if (!addr_seen) begin cap_addr = araddr; addr_seen = 1; end
            end
            if (awvalid) begin
                aw_hi++;
                if (!addr_seen) begin cap_addr = awaddr; addr_seen = 1; end
            end
            if (wvalid) begin w_hi++; cap_wdata = wdata; cap_wstrb = wstrb; end
            if (rready) rr_hi++;
            if (bready) b_hi++;
            if (rsp_valid) begin
                if (!got) begin
                    got = 1; rsp_c = c; cap_rdata = rsp_rdata; cap_resp = rsp_resp; cap_to = rsp_timeout;
                end else if (rsp_rdata !== cap_rdata || rsp_resp !== cap_resp || rsp_timeout !== cap_to) begin
                    unstable = 1;
                end
                rsp_n++;
            end
            // read address / data channels
            arready = arvalid && (ar_seen >= t.ar_w);
            if (arvalid) ar_seen++;
            if (arready) begin ar_done = 1; r_start = c + 1; end
            rvalid = ar_done && !r_done && (c >= r_start + t.r_w);
            rdata  = rvalid ? t.sdata : '0;
            rresp  = rvalid ? t.sresp : 2'b00;
            if (rvalid && rready) r_done = 1;
            // write address / data / response channels
            awready = awvalid && (aw_seen >= t.aw_w);
            if (awvalid) aw_seen++;
            if (awready) aw_hs = c;
            wready = wvalid && (w_seen >= t.w_w);
            if (wvalid) w_seen++;
            if (wready) w_hs = c;
            if (aw_hs >= 0 && w_hs >= 0 && !b_done) begin
                b_start = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1;
                bvalid  = (c >= b_start + t.b_w);
            end else begin
                bvalid = 0;
            end
            bresp = bvalid ? t.sresp : 2'b00;
            if (bvalid && bready) b_done = 1;
            rsp_ready = rsp_valid && (c >= rsp_c + t.hold);
            if (rsp_valid && rsp_ready) consumed = 1;
            @(negedge clk);
            c++;
        end
        slave_idle();
        rsp_ready = 0;

        chk({nm, " consumed"}, 64'(consumed), 64'(1));
        chk({nm, " latency"}, 64'(rsp_c), 64'(t.exp_lat));
        chk({nm, " rdata"}, cap_rdata, t.exp_rdata);
        chk({nm, " resp"}, 64'(cap_resp), 64'(t.exp_resp));
        chk({nm, " rsp_timeout"}, 64'(cap_to), 64'(0));
        chk({nm, " rsp_stable"}, 64'(unstable), 64'(0));
        chk({nm, " rsp_cycles"}, 64'(rsp_n), 64'(t.hold + 1));
        chk({nm, " ar_aw_overlap"}, 64'(overlap), 64'(0));
        chk({nm, " req_ready_busy"}, 64'(rdy_bad), 64'(0));
        chk({nm, " req_ready_after"}, 64'(req_ready), 64'(1));
        chk({nm, " rsp_valid_after"}, 64'(rsp_valid), 64'(0));
        chk({nm, " addr"}, 64'(cap_addr), 64'(exp_addr));
        if (t.wr) begin
            chk({nm, " awvalid_cycles"}, 64'(aw_hi), 64'(t.aw_w + 1));
            chk({nm, " wvalid_cycles"}, 64'(w_hi), 64'(t.w_w + 1));
            chk({nm, " bready_cycles"}, 64'(b_hi), 64'(t.b_w + 1));
            chk({nm, " wdata"}, cap_wdata, t.wd);
            chk({nm, " wstrb"}, 64'(cap_wstrb), 64'(t.ws));
            chk({nm, " arvalid_cycles"}, 64'(ar_hi), 64'(0));
        end else begin
            chk({nm, " arvalid_cycles"}, 64'(ar_hi), 64'(t.ar_w + 1));
            chk({nm, " rready_cycles"}, 64'(rr_hi), 64'(t.r_w + 1));
            chk({nm, " awvalid_cycles"}, 64'(aw_hi), 64'(0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [7:0] ctrl_bits();
        return {arvalid, awvalid, wvalid, bready, rready, rsp_valid, rsp_timeout, timed_out};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t tbl[5];
        txn_t t;
        int   c, acc, rsp_c, ar_hi, hs_bad;
        logic [DW-1:0] cap_rdata;
        logic [1:0]    cap_resp;
        logic          cap_to, cap_ar, cap_tmo;

        //           wr  addr        wdata                   strb   ar r aw w b  sdata                   sresp hold lat rdata                  resp
        tbl[0] = '{1'b0, 22'h000123, 64'h0,                  8'h00, 0, 0, 0, 0, 0, 64'hDEADBEEF_CAFEF00D, 2'b00, 0, 3, 64'hDEADBEEF_CAFEF00D, 2'b00};
        tbl[1] = '{1'b1, 22'h000040, 64'h11223344_55667788, 8'h0F, 0, 0, 2, 0, 0, 64'h0,                 2'b10, 0, 5, 64'h0,                 2'b10};
        tbl[2] = '{1'b1, 22'h0001FD, 64'hA5A5_0000_FFFF_1234, 8'hF0, 0, 0, 0, 0, 5, 64'h0,                 2'b00, 0, 8, 64'h0,                 2'b00};
        tbl[3] = '{1'b0, 22'h000207, 64'h0,                  8'h00, 0, 0, 0, 0, 0, 64'h01234567_89ABCDEF, 2'b00, 10, 3, 64'h01234567_89ABCDEF, 2'b00};
        tbl[4] = '{1'b0, 22'h3FFFFF, 64'h0,                  8'h00, 2, 1, 0, 0, 0, 64'h0F0F0F0F_F0F0F0F0, 2'b11, 0, 6, 64'h0F0F0F0F_F0F0F0F0, 2'b11};

        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 0;
        slave_idle();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'(ctrl_bits()), 64'(0));
        chk("reset_rdata", rsp_rdata, 64'(0));
        chk("reset_addr", 64'({awaddr, araddr}), 64'(0));
        rst = 0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'(1));

        for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Randomized transactions scored against the latency/response model
        for (int i = 0; i < 30; i++) begin
            t.wr    = 1'($urandom_range(0, 1));
            t.addr  = AW'($urandom);
            t.wd    = {32'($urandom), 32'($urandom)};
            t.ws    = 8'($urandom);
            t.ar_w  = $urandom_range(0, 3);
            t.r_w   = $urandom_range(0, 3);
            t.aw_w  = $urandom_range(0, 3);
            t.w_w   = $urandom_range(0, 3);
            t.b_w   = $urandom_range(0, 4);
            t.sdata = {32'($urandom), 32'($urandom)};
            t.sresp = 2'($urandom);
            t.hold  = $urandom_range(0, 3);
            t.exp_lat   = model_lat(t);
            t.exp_rdata = t.wr ? 64'h0 : t.sdata;
            t.exp_resp  = t.sresp;
            run_txn(t, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for the write response
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 22'h000088; req_wdata = 64'h55; req_wstrb = 8'hFF;
        awready = 1; wready = 1;
        c = 0;
        while (!bready && c < 20) begin
            @(negedge clk);
            if (req_ready === 1'b0) req_valid = 0;
            c++;
        end
        req_valid = 0;
        chk("wrb_reached", 64'(bready), 64'(1));
        awready = 0; wready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("wrb_reset_ctrl", 64'(ctrl_bits()), 64'(0));
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid || bready || awvalid || wvalid) acc++;
        end
        chk("wrb_reset_quiet", 64'(acc), 64'(0));
        t = tbl[0];
        run_txn(t, "post_reset_read");

        // Timeout: arready never comes
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 22'h000010;
        c = 0;
        while (!req_ready && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        req_valid = 0;
        c = 1; rsp_c = -1; ar_hi = 0;
        cap_rdata = '1; cap_resp = 0; cap_to = 0; cap_ar = 1; cap_tmo = 0;
        while (rsp_c < 0 && c < 60) begin
            if (arvalid) ar_hi++;
            if (rsp_valid) begin
                rsp_c = c; cap_rdata = rsp_rdata; cap_resp = rsp_resp;
                cap_to = rsp_timeout; cap_ar = arvalid; cap_tmo = timed_out;
                rsp_ready = 1;
            end
            @(negedge clk);
            c++;
        end
        rsp_ready = 0;
        chk("to_arvalid_cycles", 64'(ar_hi), 64'(TO));
        chk("to_rsp_cycle", 64'(rsp_c), 64'(TO + 1));
        chk("to_arvalid_low", 64'(cap_ar), 64'(0));
        chk("to_resp", 64'(cap_resp), 64'(2));
        chk("to_rdata", cap_rdata, 64'(0));
        chk("to_rsp_timeout", 64'(cap_to), 64'(1));
        chk("to_timed_out", 64'(cap_tmo), 64'(1));
        chk("to_rsp_timeout_idle", 64'(rsp_timeout), 64'(0));
        req_valid = 1; req_write = 0; req_addr = 22'h000020;
        hs_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready || arvalid || awvalid || rsp_valid || !timed_out) hs_bad++;
            @(negedge clk);
        end
        req_valid = 0;
        chk("to_sticky_block", 64'(hs_bad), 64'(0));
        do_reset();
        chk("to_cleared_by_rst", 64'(timed_out), 64'(0));
        chk("to_req_ready_after_rst", 64'(req_ready), 64'(1));
        run_txn(tbl[1], "post_timeout_write");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
